// File: rtl/intel_fpga_shared_mem_pkg.sv
// Shared definitions for the shared-memory Avalon-MM port: FSM state type
// and the per-lane byte-enable merge used by the read-modify-write path.
package intel_fpga_shared_mem_pkg;

  // Byte lane width; the data width is a whole number of these lanes.
  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_BURST = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RMW_RD   = 3'd3,
    ST_RMW_WR   = 3'd4
  } t_avmm_port_state;

  // Select the new lane when its byte enable is set, else keep the old lane.
  function automatic logic [LANE_W-1:0] merge_be(
    input logic [LANE_W-1:0] old_lane,
    input logic [LANE_W-1:0] new_lane,
    input logic              be
  );
    return be ? new_lane : old_lane;
  endfunction

endpackage

// File: rtl/intel_fpga_shared_mem_be_merge.sv
// Combinational byte-lane merge: enabled lanes come from new_word, the rest
// from old_word. Used to build the write-back word of a partial write.
module intel_fpga_shared_mem_be_merge
  import intel_fpga_shared_mem_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32
) (
  input  logic [P_DATA_WIDTH-1:0]   old_word,
  input  logic [P_DATA_WIDTH-1:0]   new_word,
  input  logic [P_DATA_WIDTH/8-1:0] be,
  output logic [P_DATA_WIDTH-1:0]   merged_word
);

  for (genvar i = 0; i < P_DATA_WIDTH / LANE_W; i++) begin : g_lane
    assign merged_word[i*LANE_W +: LANE_W] =
      merge_be(old_word[i*LANE_W +: LANE_W], new_word[i*LANE_W +: LANE_W], be[i]);
  end

endmodule

// File: rtl/intel_fpga_shared_mem_avmm_port.sv
// Avalon-MM agent for one port of the shared-memory dual-port RAM. Accepts
// read/write bursts, emulates byte enables with read-modify-write, and drives
// the RAM port with registered addr/data/re/we.
module intel_fpga_shared_mem_avmm_port
  import intel_fpga_shared_mem_pkg::*;
#(
  parameter int P_ADDR_WIDTH  = 4,
  parameter int P_DATA_WIDTH  = 32,
  parameter int P_BURST_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [P_ADDR_WIDTH-1:0]   avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [P_DATA_WIDTH-1:0]   avs_writedata,
  input  logic [P_DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic [P_BURST_WIDTH-1:0]  avs_burstcount,
  output logic                      avs_waitrequest,
  output logic [P_DATA_WIDTH-1:0]   avs_readdata,
  output logic                      avs_readdatavalid,
  output logic [P_ADDR_WIDTH-1:0]   mem_addr,
  output logic [P_DATA_WIDTH-1:0]   mem_data_in,
  output logic                      mem_re,
  output logic                      mem_we,
  input  logic [P_DATA_WIDTH-1:0]   mem_data_out
);

  localparam int BE_W = P_DATA_WIDTH / 8;
  localparam logic [P_ADDR_WIDTH-1:0]  ONE_A = P_ADDR_WIDTH'(1);
  localparam logic [P_BURST_WIDTH-1:0] ONE_B = P_BURST_WIDTH'(1);

  t_avmm_port_state          state_q, state_d;
  logic [P_ADDR_WIDTH-1:0]   addr_q;       // address of the next burst beat
  logic [P_BURST_WIDTH-1:0]  rem_q;        // beats still to come in this burst
  logic [P_DATA_WIDTH-1:0]   wdata_q;      // write data held across RMW
  logic [BE_W-1:0]           be_q;         // byte enables held across RMW
  logic [P_DATA_WIDTH-1:0]   mem_wdata_q;  // full-word write data register
  logic                      rdv_q;
  logic [P_DATA_WIDTH-1:0]   merged_word;

  logic                      wr_accept;
  logic                      rd_accept;
  logic                      be_full;
  logic                      be_none;
  logic [P_ADDR_WIDTH-1:0]   beat_addr;
  logic [P_BURST_WIDTH-1:0]  rem_next;

  intel_fpga_shared_mem_be_merge #(
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_be_merge (
    .old_word    (mem_data_out),
    .new_word    (wdata_q),
    .be          (be_q),
    .merged_word (merged_word)
  );

  // Decode the host request: acceptance, byte-enable class, beat address and count.
  always_comb begin
    wr_accept = avs_write && !avs_waitrequest;
    rd_accept = avs_read && !avs_write && !avs_waitrequest && (state_q == ST_IDLE);
    be_full   = &avs_byteenable;
    be_none   = ~|avs_byteenable;
    beat_addr = (state_q == ST_IDLE) ? avs_address : addr_q;
    if (state_q == ST_IDLE)
      rem_next = (avs_burstcount == '0) ? '0 : avs_burstcount - ONE_B;
    else
      rem_next = rem_q - ONE_B;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WR_BURST: begin
        if (wr_accept) begin
          if (!be_full && !be_none)   state_d = ST_RMW_RD;
          else if (rem_next != '0)    state_d = ST_WR_BURST;
          else                        state_d = ST_IDLE;
        end else if (rd_accept) begin
          state_d = ST_RD_BURST;
        end
      end
      ST_RD_BURST: if (rem_q == '0) state_d = ST_IDLE;
      ST_RMW_RD:   state_d = ST_RMW_WR;
      ST_RMW_WR:   state_d = (rem_q != '0) ? ST_WR_BURST : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping and registered RAM-side command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      mem_addr    <= '0;
      mem_wdata_q <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      rdv_q       <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      // Read data returns the cycle after each read issue of a burst.
      rdv_q  <= (state_q == ST_RD_BURST);
      case (state_q)
        ST_IDLE, ST_WR_BURST: begin
          if (wr_accept) begin
            addr_q  <= beat_addr + ONE_A;
            rem_q   <= rem_next;
            wdata_q <= avs_writedata;
            be_q    <= avs_byteenable;
            if (be_full) begin
              mem_we      <= 1'b1;
              mem_addr    <= beat_addr;
              mem_wdata_q <= avs_writedata;
            end else if (!be_none) begin
              mem_re   <= 1'b1;
              mem_addr <= beat_addr;
            end
          end else if (rd_accept) begin
            mem_re   <= 1'b1;
            mem_addr <= avs_address;
            addr_q   <= avs_address + ONE_A;
            rem_q    <= rem_next;
          end
        end
        ST_RD_BURST: begin
          if (rem_q != '0) begin
            mem_re   <= 1'b1;
            mem_addr <= addr_q;
            addr_q   <= addr_q + ONE_A;
            rem_q    <= rem_q - ONE_B;
          end
        end
        // Write-back of the merged word; mem_addr still holds the beat address.
        ST_RMW_RD: mem_we <= 1'b1;
        default: ;
      endcase
    end
  end

  // Host-side handshake, read data gating and RAM write data selection.
  always_comb begin
    avs_waitrequest   = rst || !((state_q == ST_IDLE) || (state_q == ST_WR_BURST));
    avs_readdatavalid = rdv_q;
    avs_readdata      = rdv_q ? mem_data_out : '0;
    // The old word is only available from the RAM during RMW_WR itself, so the
    // merged word is steered onto mem_data_in in that cycle; mem_we is registered.
    mem_data_in       = (state_q == ST_RMW_WR) ? merged_word : mem_wdata_q;
  end

endmodule

// File: tb/tb_intel_fpga_shared_mem_avmm_port.sv
// Bench for intel_fpga_shared_mem_avmm_port: directed timing scenarios plus
// randomized read/write bursts. A RAM model answers the port; an abstract
// memory image predicts read data, checked by an independent monitor.
module tb_intel_fpga_shared_mem_avmm_port;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int BEW   = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  avs_address = '0;
  logic           avs_read = 1'b0;
  logic           avs_write = 1'b0;
  logic [DW-1:0]  avs_writedata = '0;
  logic [BEW-1:0] avs_byteenable = '0;
  logic [BW-1:0]  avs_burstcount = '0;
  logic           avs_waitrequest;
  logic [DW-1:0]  avs_readdata;
  logic           avs_readdatavalid;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_data_in;
  logic           mem_re;
  logic           mem_we;
  logic [DW-1:0]  mem_data_out;

  always #5 clk = ~clk;

  intel_fpga_shared_mem_avmm_port #(
    .P_ADDR_WIDTH  (AW),
    .P_DATA_WIDTH  (DW),
    .P_BURST_WIDTH (BW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .mem_addr          (mem_addr),
    .mem_data_in       (mem_data_in),
    .mem_re            (mem_re),
    .mem_we            (mem_we),
    .mem_data_out      (mem_data_out)
  );

  // RAM port: whole-word write, registered read data.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data_in;
    if (mem_re) mem_data_out <= ram[mem_addr];
  end

  // Reference memory image and expected read-data scoreboard.
  logic [DW-1:0]  model_mem [DEPTH];
  logic [DW-1:0]  exp_q [$];
  logic [DW-1:0]  wbuf_d  [16];
  logic [BEW-1:0] wbuf_be [16];
  int vectors     = 0;
  int miscompares = 0;
  int we_count    = 0;

  always @(posedge clk) if (mem_we) we_count++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w,
                                             input logic [DW-1:0] new_w,
                                             input logic [BEW-1:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < BEW; b++)
      if (be[b]) mask = mask | (DW'(8'hFF) << (8 * b));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Monitor: every valid beat pops one expected word; idle readdata must be 0.
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) check("rdv_unexpected", DW'(avs_readdatavalid), 0);
      else                   check("readdata", avs_readdata, exp_q.pop_front());
    end else if (!rst) begin
      check("readdata_idle", avs_readdata, 0);
    end
  end

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (avs_waitrequest !== 1'b0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check({name, "_timeout"}, DW'(avs_waitrequest), 0);
  endtask

  // Issue a read burst; returns just after the accepting edge.
  task automatic do_read(input logic [AW-1:0] addr, input int burst);
    int n;
    logic [AW-1:0] a;
    n = (burst == 0) ? 1 : burst;
    a = addr;
    @(negedge clk);
    avs_read       = 1'b1;
    avs_address    = addr;
    avs_burstcount = BW'(burst);
    wait_ready("rd_accept");
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[a]);
      a = a + AW'(1);
    end
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  // Issue a write burst from wbuf_d/wbuf_be with per-beat RAM-side timing checks.
  task automatic do_write(input logic [AW-1:0] addr, input int burst, input bit gaps);
    int n;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    logic [DW-1:0]  merged;
    logic [BEW-1:0] be;
    n = (burst == 0) ? 1 : burst;
    a = addr;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          avs_read    = 1'($urandom_range(0, 1));
          avs_address = AW'($urandom);
          @(negedge clk);
        end
        avs_read = 1'b0;
      end
      d  = wbuf_d[i];
      be = wbuf_be[i];
      avs_write      = 1'b1;
      avs_address    = (i == 0) ? addr : AW'($urandom);
      avs_burstcount = (i == 0) ? BW'(burst) : BW'($urandom);
      avs_writedata  = d;
      avs_byteenable = be;
      wait_ready("wr_accept");
      merged       = apply_be(model_mem[a], d, be);
      model_mem[a] = merged;
      @(posedge clk);
      #1;
      avs_write = 1'b0;
      @(negedge clk);
      if (be == '1) begin
        check("wr_full_we",    DW'(mem_we), 1);
        check("wr_full_addr",  DW'(mem_addr), DW'(a));
        check("wr_full_data",  mem_data_in, d);
        check("wr_full_ready", DW'(avs_waitrequest), 0);
      end else if (be == '0) begin
        check("wr_zero_we", DW'(mem_we), 0);
        check("wr_zero_re", DW'(mem_re), 0);
      end else begin
        check("rmw_re",      DW'(mem_re), 1);
        check("rmw_rd_wait", DW'(avs_waitrequest), 1);
        check("rmw_rd_addr", DW'(mem_addr), DW'(a));
        @(negedge clk);
        check("rmw_we",      DW'(mem_we), 1);
        check("rmw_wr_wait", DW'(avs_waitrequest), 1);
        check("rmw_wr_addr", DW'(mem_addr), DW'(a));
        check("rmw_data",    mem_data_in, merged);
      end
      a = a + AW'(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ea;
    int we0;
    int guard;
    int r;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_wait",     DW'(avs_waitrequest), 1);
    check("rst_rdv",      DW'(avs_readdatavalid), 0);
    check("rst_readdata", avs_readdata, 0);
    check("rst_re",       DW'(mem_re), 0);
    check("rst_we",       DW'(mem_we), 0);
    check("rst_addr",     DW'(mem_addr), 0);
    check("rst_wdata",    mem_data_in, 0);
    rst = 1'b0;

    // Preload every word through the port with full-BE writes.
    for (int i = 0; i < 16; i++) begin
      wbuf_d[i]  = $urandom;
      wbuf_be[i] = '1;
    end
    wbuf_d[5] = 32'hDEADBEEF;
    wbuf_d[7] = 32'hAABBCCDD;
    do_write(4'h0, 15, 1'b0);
    wbuf_d[0] = $urandom;
    do_write(4'hF, 1, 1'b0);

    // Single read with cycle timing.
    do_read(4'h5, 1);
    @(negedge clk);
    check("sr_re",        DW'(mem_re), 1);
    check("sr_addr",      DW'(mem_addr), 5);
    check("sr_wait_high", DW'(avs_waitrequest), 1);
    check("sr_rdv_early", DW'(avs_readdatavalid), 0);
    @(negedge clk);
    check("sr_rdv",       DW'(avs_readdatavalid), 1);
    check("sr_data",      avs_readdata, 32'hDEADBEEF);
    check("sr_wait_low",  DW'(avs_waitrequest), 0);
    check("sr_re_done",   DW'(mem_re), 0);

    // Wrapping read burst 0xE..0x1.
    do_read(4'hE, 4);
    ea = 4'hE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_re",   DW'(mem_re), 1);
      check("wrap_addr", DW'(mem_addr), DW'(ea));
      check("wrap_rdv",  DW'(avs_readdatavalid), (i > 0) ? 1 : 0);
      ea = ea + AW'(1);
    end
    @(negedge clk);
    check("wrap_rdv_last", DW'(avs_readdatavalid), 1);
    check("wrap_wait_low", DW'(avs_waitrequest), 0);
    @(negedge clk);
    check("wrap_rdv_end",  DW'(avs_readdatavalid), 0);

    // Back-to-back full writes.
    wbuf_d[0] = 32'h11111111;
    wbuf_d[1] = 32'h22222222;
    wbuf_d[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) wbuf_be[i] = '1;
    we0 = we_count;
    do_write(4'h2, 3, 1'b0);
    @(negedge clk);
    check("fw_we_count", DW'(we_count - we0), 3);
    check("fw_ram2", ram[2], 32'h11111111);
    check("fw_ram3", ram[3], 32'h22222222);
    check("fw_ram4", ram[4], 32'h33333333);
    do_read(4'h2, 3);

    // Partial write via read-modify-write.
    wbuf_d[0]  = 32'h11223344;
    wbuf_be[0] = 4'b0101;
    do_write(4'h7, 1, 1'b0);
    @(negedge clk);
    check("rmw_ready", DW'(avs_waitrequest), 0);
    check("rmw_ram7",  ram[7], 32'hAA22CC44);
    do_read(4'h7, 1);

    // Zero byte-enable beat still counts toward the burst.
    wbuf_d[0]  = $urandom;
    wbuf_be[0] = '0;
    wbuf_d[1]  = 32'hCAFEF00D;
    wbuf_be[1] = '1;
    we0 = we_count;
    do_write(4'h9, 2, 1'b0);
    @(negedge clk);
    check("zbe_we_count", DW'(we_count - we0), 1);
    check("zbe_ram9",     ram[9], model_mem[9]);
    check("zbe_ram10",    ram[10], 32'hCAFEF00D);
    check("zbe_idle",     DW'(avs_waitrequest), 0);
    do_read(4'h9, 2);

    // Reset during beat 2 of an 8-beat read burst.
    do_read(4'h0, 8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_wait_high", DW'(avs_waitrequest), 1);
    @(negedge clk);
    check("mrst_rdv",  DW'(avs_readdatavalid), 0);
    check("mrst_re",   DW'(mem_re), 0);
    check("mrst_we",   DW'(mem_we), 0);
    check("mrst_addr", DW'(mem_addr), 0);
    check("mrst_wait", DW'(avs_waitrequest), 1);
    exp_q.delete();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rdv", DW'(avs_readdatavalid), 0);
      check("post_rst_re",  DW'(mem_re), 0);
    end
    do_read(4'h3, 2);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read(AW'($urandom), int'($urandom_range(0, 15)));
      end else begin
        for (int i = 0; i < 16; i++) begin
          wbuf_d[i] = $urandom;
          r = int'($urandom_range(0, 9));
          wbuf_be[i] = (r < 3) ? '1 : (r < 5) ? '0 : BEW'($urandom);
        end
        do_write(AW'($urandom), int'($urandom_range(0, 15)), 1'b1);
      end
    end

    // Drain outstanding reads, then compare the whole RAM image.
    guard = 0;
    while ((exp_q.size() != 0 || avs_waitrequest !== 1'b0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue", DW'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) check("ram_final", ram[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
